// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD pixel clock divider, raster scan counters and delayed sync strobes
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   o_lcd_clk      pixel clock, 50% duty, falls on every tick
//   o_x, o_y       pixel column / line, held at 0 outside the active area
//   o_hsync        horizontal sync, active low, SYNC_DLY pixel periods late
//   o_vsync        vertical sync, active low, SYNC_DLY pixel periods late
//   o_de           data enable, active high, SYNC_DLY pixel periods late
//   o_frame_start  one i_clk pulse after the tick that wraps the frame

module lcd_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int SYNC_DLY = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_lcd_clk,
    output logic [8:0] o_x,
    output logic [8:0] o_y,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de,
    output logic       o_frame_start
);

    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Strobe bundle layout {hsync, vsync, de}; idle value is syncs high, de low.
    localparam logic [2:0] STROBE_IDLE = 3'b110;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             tick;
    logic [9:0]       hcnt;
    logic [9:0]       vcnt;
    logic [9:0]       hcnt_next;
    logic [9:0]       vcnt_next;
    logic             h_wrap;
    logic             frame_wrap;
    logic [2:0]       strobe_next;
    logic             lcd_clk;
    logic             frame_start;

    // pipe[0] holds the strobes that belong to the current counter values;
    // pipe[SYNC_DLY] is what leaves the block.
    logic [2:0]       pipe [0:SYNC_DLY];

    always_comb begin
        tick       = (div == DIV_LAST);
        div_next   = tick ? '0 : div + DIV_ONE;
        h_wrap     = (hcnt == H_LAST);
        frame_wrap = h_wrap && (vcnt == V_LAST);
        hcnt_next  = h_wrap ? 10'd0 : hcnt + 10'd1;
        vcnt_next  = vcnt;
        if (h_wrap) begin
            vcnt_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        // Strobes are decoded from the counter values being loaded on this tick,
        // so pipe[0] changes on the same tick as the counters.
        strobe_next[2] = !((hcnt_next >= HS_FIRST) && (hcnt_next <= HS_LAST));
        strobe_next[1] = !((vcnt_next >= VS_FIRST) && (vcnt_next <= VS_LAST));
        strobe_next[0] = (hcnt_next < H_ACT) && (vcnt_next < V_ACT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            lcd_clk     <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i <= SYNC_DLY; i++) begin
                pipe[i] <= STROBE_IDLE;
            end
        end else begin
            div         <= div_next;
            // Registered from div_next so the pixel clock is high exactly while
            // div sits in the upper half, and falls on the tick.
            lcd_clk     <= (div_next >= DIV_HALF);
            frame_start <= tick && frame_wrap;
            if (tick) begin
                hcnt    <= hcnt_next;
                vcnt    <= vcnt_next;
                pipe[0] <= strobe_next;
                for (int i = 1; i <= SYNC_DLY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    // During blanking the coordinates park at 0 so layers prefetch pixel 0.
    assign o_x           = (hcnt < H_ACT) ? hcnt[8:0] : 9'd0;
    assign o_y           = (vcnt < V_ACT) ? vcnt[8:0] : 9'd0;
    assign o_lcd_clk     = lcd_clk;
    assign o_hsync       = pipe[SYNC_DLY][2];
    assign o_vsync       = pipe[SYNC_DLY][1];
    assign o_de          = pipe[SYNC_DLY][0];
    assign o_frame_start = frame_start;

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Upstream raster stage for the background and sprite layers. It divides the system clock into the LCD pixel clock and scans a 480x272 panel. It produces the pixel coordinates that the tile layers sample on the pixel-clock rising edge, and the LCD sync and data-enable strobes. The strobes are delayed by a programmable number of pixel periods so they align with the layers' registered colour output.

Parameters:
CLK_DIV, 4, i_clk cycles per pixel clock; even, >=4
H_ACTIVE, 480, visible pixels per line
H_FP, 8, horizontal front porch (pixel clocks)
H_SYNC, 4, hsync pulse width
H_BP, 43, horizontal back porch
V_ACTIVE, 272, visible lines per frame
V_FP, 8, vertical front porch (lines)
V_SYNC, 4, vsync pulse width
V_BP, 12, vertical back porch
SYNC_DLY, 1, pixel periods of delay on o_hsync/o_vsync/o_de relative to o_x/o_y; range 0..3

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
o_lcd_clk  out  1  pixel clock, 50% duty, to panel and layers
o_x  out  9  current pixel column
o_y  out  9  current line
o_hsync  out  1  horizontal sync, active low
o_vsync  out  1  vertical sync, active low
o_de  out  1  data enable, active high
o_frame_start  out  1  one i_clk pulse at frame wrap

Behaviour:
- Reset (async assert, sync release): div=0, hcnt=0, vcnt=0, delay pipes cleared.
  o_lcd_clk=0, o_x=0, o_y=0, o_hsync=1, o_vsync=1, o_de=0, o_frame_start=0.
- div counts 0..CLK_DIV-1 and wraps.
  o_lcd_clk is registered and equals 1 exactly while div is in [CLK_DIV/2, CLK_DIV-1].
  The first rising edge occurs CLK_DIV/2 i_clk cycles after reset release.
- Tick: the i_clk edge where div wraps CLK_DIV-1 -> 0. This coincides with the o_lcd_clk falling edge.
  All counters and strobes update only on a tick, so o_x/o_y are stable for CLK_DIV/2 cycles before and after every rising edge.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (535). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (296).
- On each tick, hcnt increments. At H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps to 0 after V_TOTAL-1.
- Line order: active region first, then front porch, sync, back porch. The same order applies to lines.
- o_x = hcnt when hcnt<H_ACTIVE, else 0, so the first pixel is prefetched during blanking.
- o_y = vcnt when vcnt<V_ACTIVE, else 0.
- Undelayed strobes:
  de = (hcnt<H_ACTIVE) and (vcnt<V_ACTIVE).
  hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 488..491.
  vsync low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 280..283, for the whole line.
- Strobe delay: the strobes pass through a SYNC_DLY-deep shift register that advances only on ticks.
  SYNC_DLY=0 gives outputs that change on the same tick as the counters.
  During the first SYNC_DLY pixel periods after reset, the pipes output their reset values (1,1,0).
- o_frame_start is high for exactly one i_clk cycle: the cycle following the tick on which (hcnt,vcnt) goes from (H_TOTAL-1,V_TOTAL-1) to (0,0). It is not asserted after reset.
- Arithmetic: hcnt/vcnt are 10 bits internally; o_x/o_y are truncated to 9 bits, which is lossless within the active ranges.
- Reset mid-frame: all state returns to reset values immediately. The scan restarts at (0,0) with no partial-line output and no frame_start pulse.
- No other inputs exist; the timing is free-running.

Test Plan:
- Reset release with defaults -> o_lcd_clk low for 2 cycles, then high for 2, period 4. o_x steps 0,1,2 on every falling edge. The first o_de=1 appears one pixel period (4 cycles) after the first tick.
- Run one full line -> o_x reaches 479, then 0 at hcnt 480..534. Delayed o_hsync is low for exactly 4 pixel periods (16 i_clk), starting 489 pixel periods after line start. Line period = 2140 i_clk.
- Run a full frame -> o_y counts 0..271, then holds 0. o_vsync is low for 4 lines (8560 i_clk). o_frame_start pulses once per 633440 i_clk, and is a single cycle wide.
- Sample o_x/o_y one cycle after each o_lcd_clk rising edge over 1000 pixels -> the values equal those at the preceding falling edge (stability), with no change inside the high phase.
- SYNC_DLY=0 vs 3 -> o_de rises on the same tick as o_x=0 of line 0 for SYNC_DLY=0, and 3 pixel periods later for SYNC_DLY=3. Counters are unchanged between the two.
- Assert i_rst_n low at hcnt=300, vcnt=100 for 3 cycles -> all outputs immediately take reset values. After release the scan restarts at (0,0), and no o_frame_start is seen until a full 633440 cycles have elapsed.
